// File: rtl/display_share_arbiter_if.sv
// Bundle between the two display requesters and the display share arbiter.
// The master side drives requests and digit codes; the slave side (the arbiter) drives grants and digits.
// Optional blink control is present only when DISP_BLINK_EN is defined.
interface display_share_arbiter_if;
  logic [1:0]  req;
  logic [19:0] dig0;
  logic [19:0] dig1;
`ifdef DISP_BLINK_EN
  logic [1:0]  blink;
`endif
  logic [1:0]  gnt;
  logic        busy;
  logic        owner;
  logic [4:0]  bcd0;
  logic [4:0]  bcd1;
  logic [4:0]  bcd2;
  logic [4:0]  bcd3;

  modport master (
`ifdef DISP_BLINK_EN
    output blink,
`endif
    output req, dig0, dig1,
    input  gnt, busy, owner, bcd0, bcd1, bcd2, bcd3
  );

  modport slave (
`ifdef DISP_BLINK_EN
    input  blink,
`endif
    input  req, dig0, dig1,
    output gnt, busy, owner, bcd0, bcd1, bcd2, bcd3
  );
endinterface

// File: rtl/display_share_arbiter.sv
// Round-robin share of the 4-digit seven-segment display between two requesters, min hold in prescaled ticks.
// Latency: req seen in IDLE -> gnt pulse and new digits 2 edges later; live digit update 1 cycle in SHOW.
// Backpressure: none; a requester simply keeps req high until granted. Optional blink: DISP_BLINK_EN.
module display_share_arbiter #(
  parameter int PRESC_W    = 17,
  parameter int HOLD_TICKS = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  display_share_arbiter_if.slave    io_disp
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_SHOW    = 2'd2;
  localparam logic [4:0] CODE_IDLE  = 5'h1F;
  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_TICKS - 1);

  logic [1:0]         r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [7:0]         r_hold;
  logic               r_last;
  logic               r_owner;
  logic               r_win;
  logic               r_busy;
  logic [1:0]         r_gnt;
  logic [19:0]        r_dig;

  logic               w_tick;
  logic               w_req_own;
  logic               w_req_oth;
  logic               w_expire;
  logic               w_idle_win;
  logic [19:0]        w_win_dig;
  logic [19:0]        w_own_dig;

  assign w_tick     = &r_presc;
  assign w_req_own  = io_disp.req[r_owner];
  assign w_req_oth  = io_disp.req[~r_owner];
  assign w_expire   = w_tick && (r_hold == HOLD_LAST);
  // Both requesting: the one that did not win last time goes next.
  assign w_idle_win = (&io_disp.req) ? ~r_last : io_disp.req[1];
  assign w_win_dig  = r_win   ? io_disp.dig1 : io_disp.dig0;
  assign w_own_dig  = r_owner ? io_disp.dig1 : io_disp.dig0;

  // Free-running prescaler; tick is the all-ones cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_presc <= '0;
    else       r_presc <= r_presc + 1'b1;
  end

  // Ownership FSM: pick, load for one cycle, then show with live update and hold timing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_win   <= 1'b0;
      r_busy  <= 1'b0;
      r_gnt   <= 2'b00;
      r_dig   <= {4{CODE_IDLE}};
    end else begin
      r_gnt <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          r_dig  <= {4{CODE_IDLE}};
          if (|io_disp.req) begin
            r_win   <= w_idle_win;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Completes regardless of what req does in this cycle.
          r_gnt          <= 2'b00;
          r_gnt[r_win]   <= 1'b1;
          r_owner        <= r_win;
          r_last         <= r_win;
          r_dig          <= w_win_dig;
          r_hold         <= '0;
          r_busy         <= 1'b1;
          r_state        <= ST_SHOW;
        end
        ST_SHOW: begin
          if (!w_req_own) begin
            // Owner release beats a simultaneous hold expiry.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_dig   <= {4{CODE_IDLE}};
          end else begin
            r_dig <= w_own_dig;
            if (w_expire) begin
              r_hold <= '0;
              if (w_req_oth) begin
                r_win   <= ~r_owner;
                r_state <= ST_LOAD;
              end
            end else if (w_tick) begin
              r_hold <= r_hold + 8'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_dig   <= {4{CODE_IDLE}};
        end
      endcase
    end
  end

  assign io_disp.gnt   = r_gnt;
  assign io_disp.busy  = r_busy;
  assign io_disp.owner = r_owner;

`ifdef DISP_BLINK_EN
  logic r_blink_ph;
  logic w_blank;

  // Blink phase advances on ticks while the owner asks for blinking; restarts on each new grant.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                                     r_blink_ph <= 1'b0;
    else if (r_state == ST_LOAD)                                   r_blink_ph <= 1'b0;
    else if (r_state == ST_SHOW && io_disp.blink[r_owner] && w_tick) r_blink_ph <= ~r_blink_ph;
  end

  assign w_blank      = r_blink_ph && (r_state == ST_SHOW);
  assign io_disp.bcd0 = w_blank ? CODE_BLANK : r_dig[4:0];
  assign io_disp.bcd1 = w_blank ? CODE_BLANK : r_dig[9:5];
  assign io_disp.bcd2 = w_blank ? CODE_BLANK : r_dig[14:10];
  assign io_disp.bcd3 = w_blank ? CODE_BLANK : r_dig[19:15];
`else
  assign io_disp.bcd0 = r_dig[4:0];
  assign io_disp.bcd1 = r_dig[9:5];
  assign io_disp.bcd2 = r_dig[14:10];
  assign io_disp.bcd3 = r_dig[19:15];
`endif

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with PRESC_W=2, HOLD_TICKS=2.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Rotation timing is checked against the allowed window of 6..9 edges between grants.
module tb_display_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  display_share_arbiter_if ifc ();

  display_share_arbiter #(.PRESC_W(2), .HOLD_TICKS(2)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .io_disp (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [1:0] want, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ifc.gnt == want) begin
        n = i;
        break;
      end
    end
  endtask

  int d;
  int pulses;
  int drops;

  initial begin
    ifc.req  = 2'b00;
    ifc.dig0 = 20'h0;
    ifc.dig1 = 20'h41CC5;  // digits 8,7,6,5
`ifdef DISP_BLINK_EN
    ifc.blink = 2'b00;
`endif
    // 1: reset state
    step(); step();
    chk("rst_bcd0", ifc.bcd0, 5'h1F);
    chk("rst_bcd3", ifc.bcd3, 5'h1F);
    chk("rst_gnt",  ifc.gnt,  2'b00);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_owner", ifc.owner, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_bcd1", ifc.bcd1, 5'h1F);
      chk("idle_gnt",  ifc.gnt,  2'b00);
      chk("idle_busy", ifc.busy, 1'b0);
    end

    // 2: single requester 0, grant latency and digit mapping
    ifc.dig0 = 20'h08864;
    ifc.req  = 2'b01;
    step();
    chk("t2_load_gnt",  ifc.gnt,  2'b00);
    chk("t2_load_busy", ifc.busy, 1'b0);
    step();
    chk("t2_gnt",   ifc.gnt,   2'b01);
    chk("t2_bcd0",  ifc.bcd0,  5'd4);
    chk("t2_bcd1",  ifc.bcd1,  5'd3);
    chk("t2_bcd2",  ifc.bcd2,  5'd2);
    chk("t2_bcd3",  ifc.bcd3,  5'd1);
    chk("t2_busy",  ifc.busy,  1'b1);
    chk("t2_owner", ifc.owner, 1'b0);
    step();
    chk("t2_gnt_pulse", ifc.gnt, 2'b00);
    chk("t2_busy_hold", ifc.busy, 1'b1);

    // 4: live digit update while owner holds req
    ifc.dig0 = {4{5'h09}};
    step();
    chk("t4_bcd0", ifc.bcd0, 5'h09);
    chk("t4_bcd3", ifc.bcd3, 5'h09);
    chk("t4_gnt",  ifc.gnt,  2'b00);

    // Hold expiry with only the owner requesting: no new grant, stays busy
    pulses = 0;
    drops  = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (ifc.gnt != 2'b00) pulses++;
      if (ifc.busy != 1'b1) drops++;
    end
    chk("solo_gnt_pulses", pulses, 0);
    chk("solo_busy_drops", drops, 0);

    // 5: owner 0 drops with requester 1 waiting
    ifc.req = 2'b10;
    step();
    chk("t5_idle_bcd0", ifc.bcd0, 5'h1F);
    chk("t5_idle_busy", ifc.busy, 1'b0);
    chk("t5_idle_gnt",  ifc.gnt,  2'b00);
    step();
    chk("t5_load_gnt", ifc.gnt, 2'b00);
    step();
    chk("t5_gnt",   ifc.gnt,   2'b10);
    chk("t5_owner", ifc.owner, 1'b1);
    chk("t5_bcd0",  ifc.bcd0,  5'd5);
    chk("t5_bcd3",  ifc.bcd3,  5'd8);
    ifc.req = 2'b00;
    step();
    chk("t5_release_busy", ifc.busy, 1'b0);
    step();

    // 3: both request from IDLE; last owner was 1 so 0 goes first, then rotation
    ifc.dig0 = 20'h08864;
    ifc.req  = 2'b11;
    step();
    step();
    chk("t3_gnt0",   ifc.gnt,   2'b01);
    chk("t3_owner0", ifc.owner, 1'b0);
    wait_gnt(2'b10, d);
    chk("t3_rot1_window", (d >= 6 && d <= 9), 1'b1);
    chk("t3_owner1", ifc.owner, 1'b1);
    chk("t3_bcd0_1", ifc.bcd0,  5'd5);
    wait_gnt(2'b01, d);
    chk("t3_rot2_window", (d >= 6 && d <= 9), 1'b1);
    chk("t3_owner2", ifc.owner, 1'b0);
    chk("t3_bcd0_2", ifc.bcd0,  5'd4);

    // 6: reset during SHOW, then pending request goes to requester 0
    rst = 1'b1;
    step();
    chk("t6_bcd0",  ifc.bcd0,  5'h1F);
    chk("t6_gnt",   ifc.gnt,   2'b00);
    chk("t6_busy",  ifc.busy,  1'b0);
    chk("t6_owner", ifc.owner, 1'b0);
    rst = 1'b0;
    step();
    chk("t6_load_gnt", ifc.gnt, 2'b00);
    step();
    chk("t6_gnt",    ifc.gnt,   2'b01);
    chk("t6_owner0", ifc.owner, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
